// File: rtl/shared_data_stream_encoder_m_if.sv
// AXI4-Lite host port of the shared-data stream encoder.
// Parameter AW sets the address width.
// Modport m is the host (master) side; modport s is the encoder (slave) side.
// Signals: the aw/w/b write channels and the ar/r read channels.
// The data path is 32 bits wide with a 4-bit byte strobe.
interface axi4_lite_if #(
  parameter int AW = 12
) ();
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  modport m (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport s (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/shared_data_stream_encoder_m.sv
// Transmit end of the shared-data serial link.
//
// The host fills a staging buffer of 32-bit words over AXI4-Lite. A doorbell write
// then launches one frame:
//   K 0x5C, segment byte, N*4 data bytes (word 0 first, LSB first), K 0x3C,
//   checksum high byte, checksum low byte.
// The checksum starts at 0xFFFF. The segment byte and every data byte are subtracted from it.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   shared_data_in_i   AXI4-Lite slave; buffer at 0..BUF_WORDS*4-1; doorbell at CTRL_ADDR
//   tx_ena_in          byte-slot strobe; one symbol per asserted cycle
//   tx_data_out        TX byte, registered; 0 outside symbol cycles
//   tx_isk_out         TX byte is a K-character
//   busy_out           a frame has been launched and is not yet fully sent
//
// Optional build macro SHARED_DATA_ENCODER_STATUS_RD_EN
//   When defined, AXI reads return buffer words and the {frame_cnt, busy} status.
//   When undefined, every read is answered with 0 and SLVERR.
//
// State table
//   state        | meaning
//   IDLE         | no frame; doorbell accepted here
//   SEND_START   | next slot carries K 0x5C
//   SEND_ADDR    | next slot carries the segment byte
//   SEND_DATA    | next slot carries data byte byte_idx of word word_idx
//   SEND_STOP    | next slot carries K 0x3C
//   SEND_CHKSUM  | next slot carries checksum high byte, then low byte
module shared_data_stream_encoder_m #(
  parameter int            BUF_WORDS = 16,
  parameter int            AW        = 12,
  parameter logic [AW-1:0] CTRL_ADDR = 12'h800
) (
  input  logic       clk,
  input  logic       rst,
  axi4_lite_if.s     shared_data_in_i,
  input  logic       tx_ena_in,
  output logic [7:0] tx_data_out,
  output logic       tx_isk_out,
  output logic       busy_out
);

  localparam int IDXW = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
  localparam int NW   = $clog2(BUF_WORDS + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [7:0] K_START     = 8'h5C;
  localparam logic [7:0] K_STOP      = 8'h3C;
  localparam logic [7:0] SEG_RSVD    = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    SEND_START,
    SEND_ADDR,
    SEND_DATA,
    SEND_STOP,
    SEND_CHKSUM
  } state_t;

  state_t          state;
  logic [31:0]     buf_mem [BUF_WORDS];
  logic [7:0]      seg_q;
  logic [NW-1:0]   n_q;
  logic [IDXW-1:0] word_idx;
  logic [1:0]      byte_idx;
  logic            chk_lo;
  logic [15:0]     chk_q;
  logic [15:0]     frame_cnt;

  // Write decode. Only the word address is used; awaddr[1:0] is ignored.
  logic            wr_fire;
  logic            aw_is_buf;
  logic            aw_is_ctrl;
  logic [IDXW-1:0] aw_idx;
  logic [7:0]      db_seg;
  logic [7:0]      db_n;
  logic            db_fields_ok;
  logic            buf_we;
  logic            db_ok;

  assign wr_fire      = shared_data_in_i.awready & shared_data_in_i.awvalid & shared_data_in_i.wvalid;
  assign aw_is_buf    = shared_data_in_i.awaddr[AW-1:2] < (AW-2)'(BUF_WORDS);
  assign aw_is_ctrl   = shared_data_in_i.awaddr[AW-1:2] == CTRL_ADDR[AW-1:2];
  assign aw_idx       = shared_data_in_i.awaddr[IDXW+1:2];
  assign db_seg       = shared_data_in_i.wdata[7:0];
  assign db_n         = shared_data_in_i.wdata[15:8];
  assign db_fields_ok = (db_n != 8'd0) && (db_n <= 8'(BUF_WORDS)) && (db_seg != SEG_RSVD);
  assign buf_we       = wr_fire && aw_is_buf && !busy_out;
  assign db_ok        = wr_fire && aw_is_ctrl && !busy_out && db_fields_ok;

  // Current data byte of the frame.
  logic [31:0] cur_word;
  logic [7:0]  cur_byte;
  logic        last_word;

  assign cur_word  = buf_mem[word_idx];
  assign cur_byte  = cur_word[{byte_idx, 3'b000} +: 8];
  assign last_word = (NW'(word_idx) == (n_q - NW'(1)));

  // Read path
  logic        rd_fire;
  logic [31:0] rd_data_nxt;
  logic [1:0]  rd_resp_nxt;
  logic        unused_bits;

  assign rd_fire = shared_data_in_i.arready & shared_data_in_i.arvalid;

`ifdef SHARED_DATA_ENCODER_STATUS_RD_EN
  always_comb begin
    rd_data_nxt = '0;
    rd_resp_nxt = RESP_SLVERR;
    if (shared_data_in_i.araddr[AW-1:2] < (AW-2)'(BUF_WORDS)) begin
      rd_data_nxt = buf_mem[shared_data_in_i.araddr[IDXW+1:2]];
      rd_resp_nxt = RESP_OKAY;
    end else if (shared_data_in_i.araddr[AW-1:2] == CTRL_ADDR[AW-1:2]) begin
      rd_data_nxt = {frame_cnt, 15'b0, busy_out};
      rd_resp_nxt = RESP_OKAY;
    end
  end
  assign unused_bits = ^{shared_data_in_i.awaddr[1:0], shared_data_in_i.araddr[1:0]};
`else
  assign rd_data_nxt = '0;
  assign rd_resp_nxt = RESP_SLVERR;
  assign unused_bits = ^{shared_data_in_i.awaddr[1:0], shared_data_in_i.araddr};
`endif

  // The staging buffer has no reset. Writes are blocked while a frame is in flight,
  // so the frame always sees a stable snapshot of the buffer.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      for (int b = 0; b < 4; b++) begin
        if (shared_data_in_i.wstrb[b]) begin
          buf_mem[aw_idx][8*b +: 8] <= shared_data_in_i.wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      tx_data_out              <= 8'h00;
      tx_isk_out               <= 1'b0;
      busy_out                 <= 1'b0;
      seg_q                    <= 8'h00;
      n_q                      <= '0;
      word_idx                 <= '0;
      byte_idx                 <= 2'd0;
      chk_lo                   <= 1'b0;
      chk_q                    <= 16'hFFFF;
      frame_cnt                <= 16'h0000;
      shared_data_in_i.awready <= 1'b0;
      shared_data_in_i.wready  <= 1'b0;
      shared_data_in_i.bvalid  <= 1'b0;
      shared_data_in_i.bresp   <= RESP_OKAY;
      shared_data_in_i.arready <= 1'b0;
      shared_data_in_i.rvalid  <= 1'b0;
      shared_data_in_i.rdata   <= 32'h0;
      shared_data_in_i.rresp   <= RESP_OKAY;
    end else begin
      // Write channel: ready pulses once per transaction.
      // The !awready term stops a second pulse before bvalid rises.
      shared_data_in_i.awready <= 1'b0;
      shared_data_in_i.wready  <= 1'b0;
      if (shared_data_in_i.awvalid && shared_data_in_i.wvalid &&
          !shared_data_in_i.bvalid && !shared_data_in_i.awready) begin
        shared_data_in_i.awready <= 1'b1;
        shared_data_in_i.wready  <= 1'b1;
      end
      if (wr_fire) begin
        shared_data_in_i.bvalid <= 1'b1;
        shared_data_in_i.bresp  <= (buf_we || db_ok) ? RESP_OKAY : RESP_SLVERR;
      end else if (shared_data_in_i.bvalid && shared_data_in_i.bready) begin
        shared_data_in_i.bvalid <= 1'b0;
      end

      // Read channel
      shared_data_in_i.arready <= 1'b0;
      if (shared_data_in_i.arvalid && !shared_data_in_i.rvalid && !shared_data_in_i.arready) begin
        shared_data_in_i.arready <= 1'b1;
      end
      if (rd_fire) begin
        shared_data_in_i.rvalid <= 1'b1;
        shared_data_in_i.rdata  <= rd_data_nxt;
        shared_data_in_i.rresp  <= rd_resp_nxt;
      end else if (shared_data_in_i.rvalid && shared_data_in_i.rready) begin
        shared_data_in_i.rvalid <= 1'b0;
      end

      // TX FSM: the outputs carry a symbol only in the cycle after a tx_ena_in slot.
      tx_data_out <= 8'h00;
      tx_isk_out  <= 1'b0;
      case (state)
        IDLE: begin
          if (db_ok) begin
            seg_q    <= db_seg;
            n_q      <= db_n[NW-1:0];
            chk_q    <= 16'hFFFF - {8'h00, db_seg};
            busy_out <= 1'b1;
            state    <= SEND_START;
          end
        end
        SEND_START: begin
          if (tx_ena_in) begin
            tx_data_out <= K_START;
            tx_isk_out  <= 1'b1;
            state       <= SEND_ADDR;
          end
        end
        SEND_ADDR: begin
          if (tx_ena_in) begin
            tx_data_out <= seg_q;
            word_idx    <= '0;
            byte_idx    <= 2'd0;
            state       <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (tx_ena_in) begin
            tx_data_out <= cur_byte;
            chk_q       <= chk_q - {8'h00, cur_byte};
            byte_idx    <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (last_word) begin
                state <= SEND_STOP;
              end else begin
                word_idx <= word_idx + 1'b1;
              end
            end
          end
        end
        SEND_STOP: begin
          if (tx_ena_in) begin
            tx_data_out <= K_STOP;
            tx_isk_out  <= 1'b1;
            chk_lo      <= 1'b0;
            state       <= SEND_CHKSUM;
          end
        end
        SEND_CHKSUM: begin
          if (tx_ena_in) begin
            if (!chk_lo) begin
              tx_data_out <= chk_q[15:8];
              chk_lo      <= 1'b1;
            end else begin
              tx_data_out <= chk_q[7:0];
              chk_lo      <= 1'b0;
              busy_out    <= 1'b0;
              frame_cnt   <= frame_cnt + 16'd1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_data_stream_encoder_m.sv
`timescale 1ns/1ps
module tb_shared_data_stream_encoder_m;
  localparam int          BUF_WORDS = 16;
  localparam logic [11:0] CTRL_ADDR = 12'h800;
  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_ena = 1'b0;
  logic [7:0] tx_data;
  logic       tx_isk;
  logic       busy;

  axi4_lite_if #(.AW(12)) bus ();

  shared_data_stream_encoder_m #(.BUF_WORDS(BUF_WORDS), .AW(12), .CTRL_ADDR(CTRL_ADDR)) dut (
    .clk              (clk),
    .rst              (rst),
    .shared_data_in_i (bus),
    .tx_ena_in        (tx_ena),
    .tx_data_out      (tx_data),
    .tx_isk_out       (tx_isk),
    .busy_out         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit ena_run = 1'b0;

  // Byte-slot strobe on every other cycle while ena_run is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ena = ena_run ? ~tx_ena : 1'b0;
    end
  end

  // Reference model state.
  logic [31:0] mdl_mem [BUF_WORDS];
  logic [8:0]  exp_q [$];
  logic [8:0]  rx_q [$];
  int          zero_viol = 0;
  logic        ena_q = 1'b0, busy_q = 1'b0, rst_q = 1'b0;

  // Symbol capture. A symbol is expected only after an ena slot taken while a frame
  // was in flight and reset was not asserted; every other cycle must be all zero.
  always @(negedge clk) begin
    if (ena_q && busy_q && !rst_q) rx_q.push_back({tx_isk, tx_data});
    else if (tx_isk !== 1'b0 || tx_data !== 8'h00) zero_viol++;
    ena_q  = tx_ena;
    busy_q = busy;
    rst_q  = rst;
  end

  function automatic void mdl_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    for (int k = 0; k < 4; k++)
      if (strb[k]) mdl_mem[idx][8*k +: 8] = data[8*k +: 8];
  endfunction

  function automatic void build_frame(input logic [7:0] seg, input int n);
    int sum;
    logic [7:0] b;
    logic [15:0] chk;
    exp_q.delete();
    exp_q.push_back(9'h15C);
    exp_q.push_back({1'b0, seg});
    sum = int'(seg);
    for (int w = 0; w < n; w++)
      for (int k = 0; k < 4; k++) begin
        b = mdl_mem[w][8*k +: 8];
        exp_q.push_back({1'b0, b});
        sum += int'(b);
      end
    exp_q.push_back(9'h13C);
    chk = 16'(65535 - sum);
    exp_q.push_back({1'b0, chk[15:8]});
    exp_q.push_back({1'b0, chk[7:0]});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int t;
    @(posedge clk); #1;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.awready !== 1'b1 && t < 20);
    if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL aw_handshake_timeout addr=%h awready=%b wready=%b", addr, bus.awready, bus.wready);
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    t = 0;
    while (bus.bvalid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (bus.bvalid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL bvalid_timeout addr=%h", addr);
      resp = 2'bxx;
    end else resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int t;
    @(posedge clk); #1;
    bus.araddr = addr; bus.arvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.arready !== 1'b1 && t < 20);
    if (bus.arready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL ar_handshake_timeout addr=%h", addr);
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    t = 0;
    while (bus.rvalid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (bus.rvalid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL rvalid_timeout addr=%h", addr);
      data = 'x; resp = 2'bxx;
    end else begin
      data = bus.rdata; resp = bus.rresp;
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic buf_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    axi_write(12'(idx * 4), data, strb, resp);
    if (resp === OKAY) mdl_write(idx, data, strb);
  endtask

  // Rings the doorbell, waits for the frame to drain and compares the captured stream.
  task automatic run_frame(input logic [7:0] seg, input int n, input string name);
    logic [1:0] resp;
    int t;
    build_frame(seg, n);
    rx_q.delete();
    axi_write(CTRL_ADDR, {16'h0, 8'(n), seg}, 4'hF, resp);
    checks++;
    if (resp !== OKAY) begin failures++; $display("FAIL %s_doorbell_resp got=%b exp=%b", name, resp, OKAY); end
    t = 0;
    while (busy !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
    if (busy !== 1'b0) begin checks++; failures++; $display("FAIL %s_busy_timeout busy=%b", name, busy); end
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_stream_len got=%0d exp=%0d", name, rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s_sym%0d got=%h exp=%h", name, i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (tx_data !== 8'h00 || tx_isk !== 1'b0) begin failures++; $display("FAIL reset_tx got=%h/%b exp=00/0", tx_data, tx_isk); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b%b exp=00", bus.bvalid, bus.rvalid); end
    checks++; if (bus.awready !== 1'b0 || bus.wready !== 1'b0 || bus.arready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b%b exp=000", bus.awready, bus.wready, bus.arready); end
  endtask

  task automatic test_basic_frame();
    logic [1:0] r0, r1, resp;
    logic [8:0] lit [13];
    int t;
    lit = '{9'h15C, 9'h003, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h007, 9'h008, 9'h13C, 9'h0FF, 9'h0D8};
    buf_write(0, 32'h04030201, 4'hF, r0);
    buf_write(1, 32'h08070605, 4'hF, r1);
    checks++; if (r0 !== OKAY || r1 !== OKAY) begin failures++; $display("FAIL basic_buf_resp got=%b,%b exp=00", r0, r1); end
    rx_q.delete();
    axi_write(CTRL_ADDR, 32'h0000_0203, 4'hF, resp);
    checks++; if (resp !== OKAY) begin failures++; $display("FAIL basic_doorbell_resp got=%b exp=00", resp); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%b exp=1", busy); end
    t = 0;
    while (busy !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
    if (busy !== 1'b0) begin checks++; failures++; $display("FAIL basic_busy_timeout busy=%b", busy); end
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() != 13) begin
      failures++; $display("FAIL basic_stream_len got=%0d exp=13", rx_q.size());
    end else begin
      for (int i = 0; i < 13; i++) begin
        checks++;
        if (rx_q[i] !== lit[i]) begin failures++; $display("FAIL basic_sym%0d got=%h exp=%h", i, rx_q[i], lit[i]); end
      end
    end
  endtask

  task automatic test_illegal_doorbell();
    logic [31:0] bad [4];
    logic [1:0] resp;
    bad = '{32'h0000_0003, 32'h0000_1103, 32'h0000_02FF, 32'h0000_0000};
    rx_q.delete();
    zero_viol = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) axi_write(CTRL_ADDR, bad[i], 4'hF, resp);
      else       axi_write(12'h400, 32'h0000_0203, 4'hF, resp);
      checks++; if (resp !== SLVERR) begin failures++; $display("FAIL illegal%0d_resp got=%b exp=%b", i, resp, SLVERR); end
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL illegal%0d_busy got=%b exp=0", i, busy); end
    end
    checks++;
    if (zero_viol != 0 || rx_q.size() != 0) begin
      failures++; $display("FAIL illegal_outputs got=%0d/%0d exp=0/0", zero_viol, rx_q.size());
    end
  endtask

  task automatic test_busy_writes();
    logic [1:0] resp;
    int n;
    n = $urandom_range(4, 8);
    for (int w = 0; w < n; w++) buf_write(w, $urandom, 4'hF, resp);
    fork
      run_frame(8'($urandom_range(0, 254)), n, "busywr");
      begin
        logic [1:0] r_buf, r_db;
        int t;
        t = 0;
        while (busy !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        axi_write(12'h000, 32'hDEADBEEF, 4'hF, r_buf);
        axi_write(CTRL_ADDR, 32'h0000_0101, 4'hF, r_db);
        checks++; if (r_buf !== SLVERR) begin failures++; $display("FAIL busywr_buf_resp got=%b exp=%b", r_buf, SLVERR); end
        checks++; if (r_db !== SLVERR) begin failures++; $display("FAIL busywr_db_resp got=%b exp=%b", r_db, SLVERR); end
      end
    join
  endtask

  task automatic test_wstrb_stall();
    logic [1:0] resp;
    buf_write(0, $urandom, 4'hF, resp);
    buf_write(1, $urandom, 4'hF, resp);
    buf_write(2, $urandom, 4'hF, resp);
    buf_write(0, $urandom, 4'b0010, resp);
    checks++; if (resp !== OKAY) begin failures++; $display("FAIL wstrb_resp got=%b exp=00", resp); end
    zero_viol = 0;
    fork
      run_frame(8'($urandom_range(0, 254)), 3, "stall");
      begin
        int t, sz;
        t = 0;
        while (rx_q.size() < 5 && t < 200) begin @(negedge clk); t++; end
        ena_run = 1'b0;
        repeat (3) @(negedge clk);
        sz = rx_q.size();
        repeat (20) @(negedge clk);
        checks++;
        if (rx_q.size() != sz || busy !== 1'b1) begin
          failures++; $display("FAIL stall_hold got=%0d/%b exp=%0d/1", rx_q.size(), busy, sz);
        end
        ena_run = 1'b1;
      end
    join
    checks++; if (zero_viol != 0) begin failures++; $display("FAIL stall_zero_cycles got=%0d exp=0", zero_viol); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp;
    int t;
    for (int w = 0; w < 4; w++) buf_write(w, $urandom, 4'hF, resp);
    rx_q.delete();
    axi_write(CTRL_ADDR, 32'h0000_0411, 4'hF, resp);
    t = 0;
    while (rx_q.size() < 6 && t < 200) begin @(negedge clk); t++; end
    checks++; if (rx_q.size() < 6) begin failures++; $display("FAIL rstmid_reach_data got=%0d exp=6", rx_q.size()); end
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (tx_data !== 8'h00 || tx_isk !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs got=%h/%b/%b exp=00/0/0", tx_data, tx_isk, busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int w = 0; w < 2; w++) buf_write(w, $urandom, 4'hF, resp);
    run_frame(8'($urandom_range(0, 254)), 2, "rstmid_after");
  endtask

  task automatic test_random_frames();
    logic [1:0] resp;
    int n;
    for (int f = 0; f < 3; f++) begin
      n = (f == 0) ? BUF_WORDS : (f == 1) ? 1 : int'($urandom_range(2, BUF_WORDS - 1));
      for (int w = 0; w < n; w++) begin
        buf_write(w, $urandom, 4'hF, resp);
        checks++; if (resp !== OKAY) begin failures++; $display("FAIL rand%0d_w%0d_resp got=%b exp=00", f, w, resp); end
      end
      run_frame(8'($urandom_range(0, 254)), n, $sformatf("rand%0d", f));
    end
  endtask

`ifdef SHARED_DATA_ENCODER_STATUS_RD_EN
  task automatic test_status();
    logic [31:0] d;
    logic [1:0] resp;
    do_reset();
    for (int w = 0; w < 4; w++) buf_write(w, $urandom, 4'hF, resp);
    for (int f = 0; f < 3; f++) run_frame(8'($urandom_range(0, 254)), 1, $sformatf("stat%0d", f));
    axi_read(CTRL_ADDR, d, resp);
    checks++; if (d !== 32'h0003_0000 || resp !== OKAY) begin failures++; $display("FAIL status_idle got=%h/%b exp=00030000/00", d, resp); end
    axi_read(12'h004, d, resp);
    checks++; if (d !== mdl_mem[1] || resp !== OKAY) begin failures++; $display("FAIL status_bufread got=%h/%b exp=%h/00", d, resp, mdl_mem[1]); end
    axi_read(12'h400, d, resp);
    checks++; if (d !== 32'h0 || resp !== SLVERR) begin failures++; $display("FAIL status_badaddr got=%h/%b exp=0/10", d, resp); end
    fork
      run_frame(8'h21, 4, "stat_busy");
      begin
        logic [31:0] db;
        logic [1:0] rb;
        int t;
        t = 0;
        while (busy !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        axi_read(CTRL_ADDR, db, rb);
        checks++; if (db !== 32'h0003_0001 || rb !== OKAY) begin failures++; $display("FAIL status_busy got=%h/%b exp=00030001/00", db, rb); end
      end
    join
  endtask
`else
  task automatic test_status();
    logic [31:0] d;
    logic [1:0] resp;
    axi_read(CTRL_ADDR, d, resp);
    checks++; if (d !== 32'h0 || resp !== SLVERR) begin failures++; $display("FAIL rd_ctrl got=%h/%b exp=0/10", d, resp); end
    axi_read(12'h000, d, resp);
    checks++; if (d !== 32'h0 || resp !== SLVERR) begin failures++; $display("FAIL rd_buf got=%h/%b exp=0/10", d, resp); end
  endtask
`endif

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    test_reset();
    ena_run = 1'b1;
    test_basic_frame();
    test_illegal_doorbell();
    test_busy_writes();
    test_wstrb_stall();
    test_reset_mid();
    test_random_frames();
    test_status();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
